// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package program_loader_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader_serial_sync.sv
// Two-flop synchronizer for the serial pins plus rising-edge detect on the
// synced strobe. bitValid is a one-clock pulse; bitData is the synced data bit
// at the same time.
module serial_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic serialIn,
    input  logic serialStrobe,
    output logic bitValid,
    output logic bitData
);

    logic [1:0] data_sync;
    logic [2:0] strobe_sync;  // [2] is the previous synced value for edge detect

    // Synchronize both pins with matching depth so data is stable at the strobe edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_sync   <= '0;
            strobe_sync <= '0;
        end else begin
            data_sync   <= {data_sync[0], serialIn};
            strobe_sync <= {strobe_sync[1:0], serialStrobe};
        end
    end

    assign bitValid = strobe_sync[1] & ~strobe_sync[2];
    assign bitData  = data_sync[1];

endmodule

// File: rtl/program_loader.sv
// Serial program loader: assembles 16-bit words from the bit stream, writes the
// program into instruction memory and releases the CPU once the checksum matches.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              serialIn,
    input  logic              serialStrobe,
    input  logic              start,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddress,
    output logic [WORD_W-1:0] memData,
    output logic              cpuHold,
    output logic              loadDone,
    output logic              loadError
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic              bitValid;
    logic              bitData;
    state_t            state;
    logic [WORD_W-1:0] shift;
    logic [3:0]        bitcnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len;
    logic [WORD_W-1:0] sum;
    logic [TW-1:0]     tcnt;

    logic              active;
    logic              wordDone;
    logic [WORD_W-1:0] word;
    logic              tooLong;
    logic              lastWord;

    serial_sync u_sync (
        .clock        (clock),
        .reset_n      (reset_n),
        .serialIn     (serialIn),
        .serialStrobe (serialStrobe),
        .bitValid     (bitValid),
        .bitData      (bitData)
    );

    assign active   = (state == LEN) || (state == DATA) || (state == CHECK);
    assign word     = {shift[WORD_W-2:0], bitData};
    assign wordDone = active && bitValid && (bitcnt == 4'd15);
    // Length limit compared at 17 bits so 2**ADDR_W itself is representable.
    assign tooLong  = {1'b0, word} > (WORD_W + 1)'(1 << ADDR_W);
    assign lastWord = {1'b0, idx} == (len - 1'b1);

    // Frame FSM: shift, counters, checksum, timeout and registered memory/CPU outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= '0;
            bitcnt     <= '0;
            idx        <= '0;
            len        <= '0;
            sum        <= '0;
            tcnt       <= '0;
            memWrite   <= 1'b0;
            memAddress <= '0;
            memData    <= '0;
            cpuHold    <= 1'b1;
            loadDone   <= 1'b0;
            loadError  <= 1'b0;
        end else begin
            memWrite <= 1'b0;
            if (start) begin
                // start overrides any coincident bit event
                state     <= LEN;
                bitcnt    <= '0;
                idx       <= '0;
                tcnt      <= '0;
                cpuHold   <= 1'b1;
                loadDone  <= 1'b0;
                loadError <= 1'b0;
            end else if (active) begin
                if (bitValid) begin
                    tcnt   <= '0;
                    shift  <= word;
                    bitcnt <= bitcnt + 4'd1;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state     <= ERROR;
                    loadError <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end

                if (wordDone) begin
                    case (state)
                        LEN: begin
                            if (tooLong) begin
                                state     <= ERROR;
                                loadError <= 1'b1;
                            end else begin
                                len   <= word[ADDR_W:0];
                                sum   <= '0;
                                state <= (word == '0) ? CHECK : DATA;
                            end
                        end
                        DATA: begin
                            memWrite   <= 1'b1;
                            memAddress <= idx;
                            memData    <= word;
                            sum        <= sum + word;
                            // index stops at the last word so it never wraps
                            if (lastWord) state <= CHECK;
                            else          idx   <= idx + 1'b1;
                        end
                        CHECK: begin
                            if (word == sum) begin
                                state    <= DONE;
                                loadDone <= 1'b1;
                                cpuHold  <= 1'b0;
                            end else begin
                                state     <= ERROR;
                                loadError <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
